// File: rtl/if_id_pipe_pkg.sv
// Shared types and constants for the IF/ID pipeline register.
package if_id_pipe_pkg;

    // Occupancy of the two-entry buffer: nothing, main only, main plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    // Level of rst that resets the block.
    localparam logic RST_ACTIVE = 1'b1;

    // Single zero bit, replicated to build a zero word of any width.
    localparam logic ZERO_BIT = 1'b0;

endpackage

// File: rtl/if_id_pipe_sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);
    import if_id_pipe_pkg::*;

    localparam logic [WIDTH-1:0] INC_STEP = {{(WIDTH-1){ZERO_BIT}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Advance by one unless already at all-ones, so the count never wraps.
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + INC_STEP;
        end
    end

    // Synchronous clear has priority over counting.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            count_q <= {WIDTH{ZERO_BIT}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/if_id_pipe.sv
// IF/ID pipeline register with a skid entry so in_ready can be registered,
// plus stall and flush performance counters.
module if_id_pipe
    import if_id_pipe_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [INST_W-1:0] in_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    pipe_state_e       state_q, state_d;
    logic              in_ready_q;
    logic [ADDR_W-1:0] main_pc_q, main_pc_d;
    logic [INST_W-1:0] main_inst_q, main_inst_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic [INST_W-1:0] skid_inst_q, skid_inst_d;
    logic              push;
    logic              pop;
    logic              rst_hit;

    assign rst_hit = (rst == RST_ACTIVE);
    assign push    = in_valid && in_ready_q;
    assign pop     = out_valid && out_ready;

    // State and in_ready register; in_ready tracks "next state is not FULL".
    always_ff @(posedge clk) begin
        if (rst_hit) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    // Entry storage; contents only matter while state marks them occupied.
    always_ff @(posedge clk) begin
        main_pc_q   <= main_pc_d;
        main_inst_q <= main_inst_d;
        skid_pc_q   <= skid_pc_d;
        skid_inst_q <= skid_inst_d;
    end

    // Next-state and data movement; flush beats every transfer.
    always_comb begin
        state_d     = state_q;
        main_pc_d   = main_pc_q;
        main_inst_d = main_inst_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d     = ONE;
                        main_pc_d   = in_pc;
                        main_inst_d = in_inst;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_pc_d   = in_pc;
                        main_inst_d = in_inst;
                    end else if (push) begin
                        state_d     = FULL;
                        skid_pc_d   = in_pc;
                        skid_inst_d = in_inst;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d     = ONE;
                        main_pc_d   = skid_pc_q;
                        main_inst_d = skid_inst_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Outputs: the main entry when occupied, a bubble when empty.
    always_comb begin
        in_ready  = in_ready_q;
        out_valid = 1'b0;
        out_pc    = {ADDR_W{ZERO_BIT}};
        out_inst  = NOP_INST;
        if (state_q != EMPTY) begin
            out_valid = 1'b1;
            out_pc    = main_pc_q;
            out_inst  = main_inst_q;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .clr_i   (rst_hit),
        .inc_i   (out_valid && !out_ready),
        .count_o (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .clr_i   (rst_hit),
        .inc_i   (flush && (state_q != EMPTY)),
        .count_o (flush_cnt)
    );

endmodule

// File: doc/if_id_pipe.md
IF_ID_PIPE -- requirements
Module: if_id_pipe

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning PC width in bits.
REQ-002 The block SHALL have parameter INST_W, default 32, meaning instruction width in bits.
REQ-003 The block SHALL have parameter NOP_INST, default all-zero INST_W, meaning the bubble instruction presented when empty.
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning performance-counter width.
REQ-005 The block SHALL have port clk, input, 1, meaning the system clock; all state updates on rising edge.
REQ-006 The block SHALL have port rst, input, 1, meaning reset, synchronous, active-high.
REQ-007 The block SHALL have port flush, input, 1, meaning discard all held and incoming entries (branch redirect).
REQ-008 The block SHALL have port in_valid, input, 1, meaning the IF side offers an entry.
REQ-009 The block SHALL have port in_ready, output, 1, meaning the block can accept an entry this cycle.
REQ-010 The block SHALL have port in_pc, input, ADDR_W, meaning the fetched PC.
REQ-011 The block SHALL have port in_inst, input, INST_W, meaning the fetched instruction.
REQ-012 The block SHALL have port out_valid, output, 1, meaning an entry is presented to ID.
REQ-013 The block SHALL have port out_ready, input, 1, meaning ID consumes the presented entry this cycle.
REQ-014 The block SHALL have port out_pc, output, ADDR_W, meaning the PC presented to ID.
REQ-015 The block SHALL have port out_inst, output, INST_W, meaning the instruction presented to ID.
REQ-016 The block SHALL have port stall_cnt, output, CNT_W, meaning the count of cycles with out_valid=1 and out_ready=0.
REQ-017 The block SHALL have port flush_cnt, output, CNT_W, meaning the count of flush cycles that discarded at least one valid entry.

Function
REQ-018 Storage SHALL be two entries: main (drives outputs) and skid; states EMPTY (none), ONE (main only), FULL (main+skid).
REQ-019 Transfer in SHALL occur when in_valid && in_ready; transfer out SHALL occur when out_valid && out_ready.
REQ-020 in_ready SHALL be a registered signal equal to 1 in EMPTY and ONE and 0 in FULL; it SHALL NOT depend combinationally on out_ready.
REQ-021 out_valid SHALL be 1 in ONE and FULL, and 0 in EMPTY.
REQ-022 In EMPTY, out_pc SHALL be 0 and out_inst SHALL be NOP_INST.
REQ-023 Latency SHALL be one cycle: an entry accepted in EMPTY at edge N appears on out_* after edge N.
REQ-024 Throughput SHALL be one entry per cycle when out_ready is held 1; order SHALL be preserved.
REQ-025 EMPTY transitions: transfer in -> ONE; otherwise stay.
REQ-026 ONE transitions: in and out together -> ONE with new main; in only -> FULL with the new entry in skid; out only -> EMPTY; otherwise stay.
REQ-027 FULL transitions: out -> ONE with skid moved to main; otherwise stay (no input accepted).
REQ-028 flush=1 SHALL force EMPTY at the next edge, discard main, skid and any same-cycle input, and take priority over all transfers.
REQ-029 in_ready SHALL be 1 in the cycle after a flush.
REQ-030 stall_cnt and flush_cnt SHALL saturate at all-ones and never wrap.
REQ-031 flush_cnt SHALL increment only if flush=1 and the state is ONE or FULL.
REQ-032 Held entries SHALL remain stable while out_valid && !out_ready.

Reset
REQ-033 rst=1 at a clock edge SHALL force EMPTY, in_ready=1, out_valid=0, out_pc=0, out_inst=NOP_INST, stall_cnt=0 and flush_cnt=0, overriding flush and all transfers.
REQ-034 Reset asserted mid-operation SHALL discard both entries with no partial transfer.

Structure
REQ-035 The state enum (EMPTY/ONE/FULL), the reset polarity constant and the zero-word constant SHALL reside in the shared defines/package.
REQ-036 One sub-module, sat_counter (parametrised width, inc, clr), SHALL be instantiated twice for the counters; all other logic SHALL be flat.

Verification
REQ-037 The bench SHALL cover: after rst, in_valid=1, pc=0x100, inst=0x00A00093, out_ready=1 -> out_valid=1 with those values one cycle later, in_ready stays 1.
REQ-038 The bench SHALL cover: stream pc 0x0,0x4,0x8,0xC with out_ready=1 -> the same sequence out at 1 per cycle, stall_cnt=0.
REQ-039 The bench SHALL cover: out_ready=0 with two inputs 0x10, 0x14 -> FULL, in_ready=0, out_pc=0x10 held; then out_ready=1 -> 0x10 then 0x14, stall_cnt counts held cycles exactly.
REQ-040 The bench SHALL cover: FULL plus flush=1 with in_valid=1 pc=0x20 -> next cycle out_valid=0, out_inst=NOP_INST, in_ready=1, flush_cnt=1, 0x20 never output.
REQ-041 The bench SHALL cover: rst=1 together with flush=1 and in_valid=1 in state ONE -> EMPTY with both counters 0.
REQ-042 The bench SHALL cover: CNT_W=4, out_ready=0 held for 20 cycles -> stall_cnt saturates at 15.
